rp_8bit_asm_enc: RTL and testbench
==================================

Name: rp_8bit_asm_enc

Overview:
Instruction encoder (assembler back end) for the rp_8bit core, the inverse of the disassembler. It accepts one symbolic instruction per handshake as an op code plus operand fields. It emits the AVR 16-bit program word stream over a valid/ready interface: one word for most instructions, two words for jmp/call/lds/sts. Used by testbenches and the program-memory loader to build images from instruction lists, with operand range checking.

Parameters:
CW, 16, width of emitted-word counter o_cnt

Ports:
clk     in   1   clock
rst     in   1   reset, synchronous, active-high
i_vld   in   1   instruction valid
i_rdy   out  1   encoder can accept instruction
i_op    in   5   op code (see Behaviour)
i_rd    in   5   destination register / Rd
i_rr    in   5   source register / Rr
i_b     in   3   SREG bit index (brbs/brbc)
i_k     in   22  immediate / IO address / data address / word offset (signed where stated)
o_vld   out  1   output word valid
o_rdy   in   1   consumer accepts word
o_word  out  16  program word
o_last  out  1   final word of current instruction
o_err   out  1   one-cycle pulse: rejected instruction
o_cnt   out  CW  words emitted since reset

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: o_vld=0, o_word=0, o_last=0, o_err=0, o_cnt=0; FSM=EMPTY; pending second word cleared.
- Op codes and encodings (d=i_rd, r=i_rr, K=i_k[7:0], h=i_rd-16):
  0 nop 0x0000 | 1 mov 0x2C00 | 2 add 0x0C00 | 3 adc 0x1C00 | 4 sub 0x1800 | 5 sbc 0x0800 | 6 and 0x2000 | 7 or 0x2800 | 8 eor 0x2400 | 9 cp 0x1400 | 10 cpc 0x0400 | 11 cpse 0x1000. Two-register ops OR in r[4]<<9, d<<4, r[3:0].
  12 ldi 0xE000 | 13 cpi 0x3000 | 14 subi 0x5000 | 15 sbci 0x4000 | 16 ori 0x6000 | 17 andi 0x7000. Immediate ops OR in K[7:4]<<8, h<<4, K[3:0]. Illegal if i_rd<16 or i_k>255.
  18 rjmp 0xC000 | 19 rcall 0xD000. Low 12 bits are i_k[11:0]. i_k is signed, in words; illegal unless -2048..2047.
  20 jmp and 21 call: word1 = 0x940C|0x0002(call) | i_k[21:17]<<4 | i_k[16]. word2 = i_k[15:0].
  22 lds word1 = 0x9000|d<<4. 23 sts word1 = 0x9200|r<<4. word2 = i_k[15:0]. Illegal if i_k>0xFFFF.
  24 in 0xB000 and 25 out 0xB800: OR in A[5:4]<<9, reg<<4, A[3:0], where A=i_k. in uses d; out uses r. Illegal if i_k>63.
  26 push 0x920F|r<<4 | 27 pop 0x900F|d<<4 | 28 ret 0x9508 | 29 reti 0x9518.
  30 brbs 0xF000 | 31 brbc 0xF400. OR in i_k[6:0]<<3, i_b. i_k is signed words; illegal unless -64..63.
- Unused fields are ignored (no error).
- FSM states:
  EMPTY: no word held.
  ONE: holding a single word, o_last=1.
  W1: holding word1 of a two-word instruction, o_last=0; word2 held internally.
  W2: holding word2, o_last=1.
- i_rdy = (state==EMPTY) | ((state==ONE|W2) & o_rdy). Combinational, no dependency on i_vld.
- Accept (i_vld&i_rdy) on a legal instruction: the next cycle shows o_vld=1 with word1, giving 1-cycle latency. Next state is ONE or W1.
- Accept on an illegal instruction: o_err=1 the next cycle, nothing emitted. State goes to EMPTY (or stays EMPTY), o_cnt unchanged.
- Back-to-back: accepting in the same cycle the last word is consumed gives the next word with no bubble.
- W1 & o_rdy -> W2. ONE/W2 & o_rdy & !accept -> EMPTY.
- o_vld & !o_rdy: o_word and o_last hold stable; i_rdy=0.
- o_cnt increments on every o_vld&o_rdy and wraps modulo 2^CW.
- rst mid-instruction (e.g. in W1) discards the pending word2; no partial continuation.

Test Plan:
- ldi r16,0xFF (op12, rd=16, k=0xFF), o_rdy=1 -> one word 0xEF0F, o_last=1, o_cnt=1.
- add r1,r2 then push r31 back-to-back, o_rdy=1 -> 0x0C12, 0x93FF on consecutive cycles; i_rdy stays 1.
- jmp 0x001234 with o_rdy low for 3 cycles -> 0x940C held stable with o_last=0, then 0x1234 with o_last=1; i_rdy=0 until word2 is consumed; o_cnt increases by 2.
- rjmp k=-1 -> 0xCFFF. brbc b=1, k=-2 -> 0xF7F1. ret -> 0x9508.
- Illegal inputs: ldi r5; in with k=64; op value out of range none (all 32 op codes defined) -> use cpi k=0x100 -> o_err pulse, no o_vld, o_cnt unchanged.
- lds r3,0xABCD with rst asserted while in W1 -> all outputs at reset values next cycle; 0xABCD never emitted.

Source files
------------

// File: rtl/rp_8bit_asm_enc_if.sv
// rp_8bit assembler back end: instruction in, program words out.
// master drives instructions and o_rdy; slave is the encoder.
interface rp_8bit_asm_enc_if #(
  parameter int CW = 16
);
  logic          i_vld;
  logic          i_rdy;
  logic [4:0]    i_op;
  logic [4:0]    i_rd;
  logic [4:0]    i_rr;
  logic [2:0]    i_b;
  logic [21:0]   i_k;
  logic          o_vld;
  logic          o_rdy;
  logic [15:0]   o_word;
  logic          o_last;
  logic          o_err;
  logic [CW-1:0] o_cnt;

  modport master (
    output i_vld, i_op, i_rd, i_rr, i_b, i_k, o_rdy,
    input  i_rdy, o_vld, o_word, o_last, o_err, o_cnt
  );

  modport slave (
    input  i_vld, i_op, i_rd, i_rr, i_b, i_k, o_rdy,
    output i_rdy, o_vld, o_word, o_last, o_err, o_cnt
  );
endinterface

// File: rtl/rp_8bit_asm_enc.sv
// rp_8bit instruction encoder: symbolic op + operands -> AVR words.
// Two-word ops (jmp/call/lds/sts) park word2 until word1 drains.
module rp_8bit_asm_enc #(
  parameter int CW = 16
) (
  input logic clk,
  input logic rst,
  rp_8bit_asm_enc_if.slave bus
);
  typedef enum logic [1:0] {
    EMPTY, ONE, W1, W2
  } state_t;

  state_t        state, state_n;
  logic [15:0]   word_q, word_n;
  logic [15:0]   w2_q, w2_n;
  logic          err_q, err_n;
  logic [CW-1:0] cnt_q;

  logic [15:0] enc1, enc2;
  logic        two, ill;
  logic [4:0]  d, r;
  logic [21:0] k;
  logic        k8_ovf, k16_ovf, k6_ovf;
  logic        s12_ok, s7_ok;
  logic [15:0] rr_f, im_f, br_f;
  logic        accept, take;

  assign d = bus.i_rd;
  assign r = bus.i_rr;
  assign k = bus.i_k;

  assign k8_ovf  = |k[21:8];
  assign k16_ovf = |k[21:16];
  assign k6_ovf  = |k[21:6];
  // signed word offsets: upper bits must be pure sign extension
  assign s12_ok  = (&k[21:11]) | ~(|k[21:11]);
  assign s7_ok   = (&k[21:6]) | ~(|k[21:6]);

  assign rr_f = {6'b0, r[4], d, r[3:0]};
  assign im_f = {4'b0, k[7:4], d[3:0], k[3:0]};
  assign br_f = {6'b0, k[6:0], bus.i_b};

  always_comb begin
    enc1 = 16'h0000;
    enc2 = k[15:0];
    two  = 1'b0;
    ill  = 1'b0;
    unique case (bus.i_op)
      5'd0:  enc1 = 16'h0000;
      5'd1:  enc1 = 16'h2C00 | rr_f;
      5'd2:  enc1 = 16'h0C00 | rr_f;
      5'd3:  enc1 = 16'h1C00 | rr_f;
      5'd4:  enc1 = 16'h1800 | rr_f;
      5'd5:  enc1 = 16'h0800 | rr_f;
      5'd6:  enc1 = 16'h2000 | rr_f;
      5'd7:  enc1 = 16'h2800 | rr_f;
      5'd8:  enc1 = 16'h2400 | rr_f;
      5'd9:  enc1 = 16'h1400 | rr_f;
      5'd10: enc1 = 16'h0400 | rr_f;
      5'd11: enc1 = 16'h1000 | rr_f;
      5'd12: begin
        enc1 = 16'hE000 | im_f;
        ill  = ~d[4] | k8_ovf;
      end
      5'd13: begin
        enc1 = 16'h3000 | im_f;
        ill  = ~d[4] | k8_ovf;
      end
      5'd14: begin
        enc1 = 16'h5000 | im_f;
        ill  = ~d[4] | k8_ovf;
      end
      5'd15: begin
        enc1 = 16'h4000 | im_f;
        ill  = ~d[4] | k8_ovf;
      end
      5'd16: begin
        enc1 = 16'h6000 | im_f;
        ill  = ~d[4] | k8_ovf;
      end
      5'd17: begin
        enc1 = 16'h7000 | im_f;
        ill  = ~d[4] | k8_ovf;
      end
      5'd18: begin
        enc1 = {4'hC, k[11:0]};
        ill  = ~s12_ok;
      end
      5'd19: begin
        enc1 = {4'hD, k[11:0]};
        ill  = ~s12_ok;
      end
      5'd20, 5'd21: begin
        enc1 = 16'h940C | {7'b0, k[21:17], 3'b0, k[16]};
        enc1 = enc1 | {14'b0, bus.i_op[0], 1'b0};
        two  = 1'b1;
      end
      5'd22: begin
        enc1 = 16'h9000 | {7'b0, d, 4'b0};
        two  = 1'b1;
        ill  = k16_ovf;
      end
      5'd23: begin
        enc1 = 16'h9200 | {7'b0, r, 4'b0};
        two  = 1'b1;
        ill  = k16_ovf;
      end
      5'd24: begin
        enc1 = 16'hB000 | {5'b0, k[5:4], d, k[3:0]};
        ill  = k6_ovf;
      end
      5'd25: begin
        enc1 = 16'hB800 | {5'b0, k[5:4], r, k[3:0]};
        ill  = k6_ovf;
      end
      5'd26: enc1 = 16'h920F | {7'b0, r, 4'b0};
      5'd27: enc1 = 16'h900F | {7'b0, d, 4'b0};
      5'd28: enc1 = 16'h9508;
      5'd29: enc1 = 16'h9518;
      5'd30: begin
        enc1 = 16'hF000 | br_f;
        ill  = ~s7_ok;
      end
      5'd31: begin
        enc1 = 16'hF400 | br_f;
        ill  = ~s7_ok;
      end
    endcase
  end

  assign bus.i_rdy  = (state == EMPTY) |
                      (((state == ONE) | (state == W2)) & bus.o_rdy);
  assign bus.o_vld  = (state != EMPTY);
  assign bus.o_last = (state == ONE) | (state == W2);
  assign bus.o_word = word_q;
  assign bus.o_err  = err_q;
  assign bus.o_cnt  = cnt_q;

  assign accept = bus.i_vld & bus.i_rdy;
  assign take   = bus.o_vld & bus.o_rdy;

  always_comb begin
    state_n = state;
    word_n  = word_q;
    w2_n    = w2_q;
    err_n   = 1'b0;
    if (take) begin
      if (state == W1) begin
        state_n = W2;
        word_n  = w2_q;
      end else begin
        state_n = EMPTY;
      end
    end
    if (accept) begin
      if (ill) begin
        err_n   = 1'b1;
        state_n = EMPTY;
      end else begin
        word_n  = enc1;
        w2_n    = enc2;
        state_n = two ? W1 : ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      word_q <= 16'h0000;
      w2_q   <= 16'h0000;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      word_q <= word_n;
      w2_q   <= w2_n;
      err_q  <= err_n;
      if (take)
        cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_rp_8bit_asm_enc.sv
// Bench for rp_8bit_asm_enc: directed scenarios plus a randomized
// run scored against an arithmetic model of the encoding rules.
module tb_rp_8bit_asm_enc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   exp_cnt = 0;

  rp_8bit_asm_enc_if #(.CW(16)) bus ();

  rp_8bit_asm_enc #(.CW(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // words for one instruction, from the encoding rules
  function automatic void enc(
    input int op, input int rd, input int rr,
    input int b, input int k,
    output bit err, output int n,
    output int w1, output int w2
  );
    int base[12];
    int imb[6];
    int sk;
    base = '{'h0000, 'h2C00, 'h0C00, 'h1C00, 'h1800, 'h0800,
             'h2000, 'h2800, 'h2400, 'h1400, 'h0400, 'h1000};
    imb  = '{'hE000, 'h3000, 'h5000, 'h4000, 'h6000, 'h7000};
    sk = (k >= 2097152) ? k - 4194304 : k;
    err = 0; n = 1; w1 = 0; w2 = k % 65536;
    if (op == 0) w1 = 0;
    else if (op <= 11)
      w1 = base[op] + (rr / 16) * 512 + rd * 16 + rr % 16;
    else if (op <= 17) begin
      err = (rd < 16) || (k > 255);
      w1 = imb[op-12] + (k % 256 / 16) * 256
         + (rd % 16) * 16 + k % 16;
    end else if (op <= 19) begin
      err = (sk < -2048) || (sk > 2047);
      w1 = (op == 18 ? 'hC000 : 'hD000) + (sk + 8192) % 4096;
    end else if (op <= 21) begin
      n = 2;
      w1 = 'h940C + (op == 21 ? 2 : 0)
         + (k / 131072) * 16 + (k / 65536) % 2;
    end else if (op <= 23) begin
      n = 2;
      err = k > 65535;
      w1 = (op == 22) ? 'h9000 + rd * 16 : 'h9200 + rr * 16;
    end else if (op <= 25) begin
      err = k > 63;
      w1 = (op == 24 ? 'hB000 + rd * 16 : 'hB800 + rr * 16)
         + (k % 64 / 16) * 512 + k % 16;
    end else if (op == 26) w1 = 'h920F + rr * 16;
    else if (op == 27) w1 = 'h900F + rd * 16;
    else if (op == 28) w1 = 'h9508;
    else if (op == 29) w1 = 'h9518;
    else begin
      err = (sk < -64) || (sk > 63);
      w1 = (op == 30 ? 'hF000 : 'hF400)
         + ((sk + 256) % 128) * 8 + b;
    end
  endfunction

  task automatic idle();
    bus.i_vld = 0;
    bus.i_op = 0;
    bus.i_rd = 0;
    bus.i_rr = 0;
    bus.i_b = 0;
    bus.i_k = 0;
  endtask

  task automatic put(input int op, input int rd, input int rr,
                     input int b, input int k);
    bus.i_vld = 1;
    bus.i_op = 5'(op);
    bus.i_rd = 5'(rd);
    bus.i_rr = 5'(rr);
    bus.i_b = 3'(b);
    bus.i_k = 22'(k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus.o_rdy = 1;
    rst = 1;
    tick(); tick();
    rst = 0;
    tests++;
    if ({bus.o_vld, bus.o_last, bus.o_err} !== 3'b000 ||
        bus.o_word !== 16'h0 || bus.o_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset: vld=%b last=%b err=%b word=%h cnt=%0d, want zeros",
               bus.o_vld, bus.o_last, bus.o_err, bus.o_word, bus.o_cnt);
    end
    tests++;
    if (bus.i_rdy !== 1'b1) begin
      fails++;
      $display("FAIL reset_rdy: i_rdy=%b want 1", bus.i_rdy);
    end
    exp_cnt = 0;
  endtask

  task automatic test_ldi();
    bus.o_rdy = 1;
    put(12, 16, 0, 0, 'hFF);
    tick();
    idle();
    tests++;
    if (bus.o_vld !== 1 || bus.o_word !== 16'hEF0F || bus.o_last !== 1) begin
      fails++;
      $display("FAIL ldi: vld=%b word=%h last=%b want 1 EF0F 1",
               bus.o_vld, bus.o_word, bus.o_last);
    end
    tick();
    exp_cnt++;
    tests++;
    if (bus.o_vld !== 0 || bus.o_cnt !== 16'(exp_cnt)) begin
      fails++;
      $display("FAIL ldi_cnt: vld=%b cnt=%0d want 0 %0d",
               bus.o_vld, bus.o_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bus.o_rdy = 1;
    put(2, 1, 2, 0, 0);
    tick();
    put(26, 0, 31, 0, 0);
    #1;
    tests++;
    if (bus.o_word !== 16'h0C12 || bus.i_rdy !== 1) begin
      fails++;
      $display("FAIL b2b_add: word=%h i_rdy=%b want 0C12 1",
               bus.o_word, bus.i_rdy);
    end
    tick();
    idle();
    tests++;
    if (bus.o_vld !== 1 || bus.o_word !== 16'h93FF || bus.o_last !== 1) begin
      fails++;
      $display("FAIL b2b_push: vld=%b word=%h last=%b want 1 93FF 1",
               bus.o_vld, bus.o_word, bus.o_last);
    end
    tick();
    exp_cnt += 2;
  endtask

  task automatic test_jmp_stall();
    bus.o_rdy = 0;
    put(20, 0, 0, 0, 'h1234);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (bus.o_vld !== 1 || bus.o_word !== 16'h940C ||
          bus.o_last !== 0 || bus.i_rdy !== 0) begin
        fails++;
        $display("FAIL jmp_w1[%0d]: vld=%b word=%h last=%b rdy=%b want 1 940C 0 0",
                 i, bus.o_vld, bus.o_word, bus.o_last, bus.i_rdy);
      end
      tick();
    end
    bus.o_rdy = 1;
    #1;
    tests++;
    if (bus.i_rdy !== 0) begin
      fails++;
      $display("FAIL jmp_rdy_w1: i_rdy=%b want 0", bus.i_rdy);
    end
    tick();
    tests++;
    if (bus.o_word !== 16'h1234 || bus.o_last !== 1 || bus.i_rdy !== 1) begin
      fails++;
      $display("FAIL jmp_w2: word=%h last=%b rdy=%b want 1234 1 1",
               bus.o_word, bus.o_last, bus.i_rdy);
    end
    tick();
    exp_cnt += 2;
    tests++;
    if (bus.o_vld !== 0 || bus.o_cnt !== 16'(exp_cnt)) begin
      fails++;
      $display("FAIL jmp_cnt: vld=%b cnt=%0d want 0 %0d",
               bus.o_vld, bus.o_cnt, exp_cnt);
    end
  endtask

  task automatic test_single_words();
    int ops[3] = '{18, 31, 28};
    int bs[3]  = '{0, 1, 0};
    int ks[3]  = '{'h3FFFFF, 'h3FFFFE, 0};
    logic [15:0] want[3] = '{16'hCFFF, 16'hF7F1, 16'h9508};
    bus.o_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      put(ops[i], 0, 0, bs[i], ks[i]);
      tick();
      idle();
      tests++;
      if (bus.o_vld !== 1 || bus.o_word !== want[i] || bus.o_last !== 1) begin
        fails++;
        $display("FAIL single[%0d]: vld=%b word=%h last=%b want 1 %h 1",
                 i, bus.o_vld, bus.o_word, bus.o_last, want[i]);
      end
      tick();
      exp_cnt++;
    end
  endtask

  task automatic test_illegal();
    int ops[3] = '{12, 24, 13};
    int rds[3] = '{5, 0, 20};
    int ks[3]  = '{1, 64, 'h100};
    bus.o_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      put(ops[i], rds[i], 0, 0, ks[i]);
      tick();
      idle();
      tests++;
      if (bus.o_err !== 1 || bus.o_vld !== 0) begin
        fails++;
        $display("FAIL illegal[%0d]: err=%b vld=%b want 1 0",
                 i, bus.o_err, bus.o_vld);
      end
      tick();
      tests++;
      if (bus.o_err !== 0 || bus.o_vld !== 0 ||
          bus.o_cnt !== 16'(exp_cnt)) begin
        fails++;
        $display("FAIL illegal_after[%0d]: err=%b vld=%b cnt=%0d want 0 0 %0d",
                 i, bus.o_err, bus.o_vld, bus.o_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_rst_mid();
    bus.o_rdy = 0;
    put(22, 3, 0, 0, 'hABCD);
    tick();
    idle();
    tests++;
    if (bus.o_word !== 16'h9030 || bus.o_last !== 0) begin
      fails++;
      $display("FAIL lds_w1: word=%h last=%b want 9030 0",
               bus.o_word, bus.o_last);
    end
    rst = 1;
    tick();
    rst = 0;
    exp_cnt = 0;
    tests++;
    if ({bus.o_vld, bus.o_last, bus.o_err} !== 3'b000 ||
        bus.o_word !== 16'h0 || bus.o_cnt !== 16'h0) begin
      fails++;
      $display("FAIL rst_mid: vld=%b last=%b err=%b word=%h cnt=%0d want zeros",
               bus.o_vld, bus.o_last, bus.o_err, bus.o_word, bus.o_cnt);
    end
    bus.o_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (bus.o_vld !== 0 || bus.o_word === 16'hABCD) begin
        fails++;
        $display("FAIL rst_mid_after[%0d]: vld=%b word=%h want 0, no ABCD",
                 i, bus.o_vld, bus.o_word);
      end
    end
  endtask

  task automatic test_random();
    int q[$];
    bit err_exp = 0;
    bit err_nx, e;
    int n, w1, w2, op, rd, rr, b, k, sel;
    bit acc, rdy_exp, or_v;
    idle();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tests++;
      if (bus.o_err !== err_exp || bus.o_vld !== (q.size() > 0)) begin
        fails++;
        $display("FAIL rnd_state[%0d]: err=%b vld=%b want %b %b",
                 cyc, bus.o_err, bus.o_vld, err_exp, q.size() > 0);
      end
      if (q.size() > 0) begin
        tests++;
        if (bus.o_word !== 16'(q[0]) || bus.o_last !== (q.size() == 1)) begin
          fails++;
          $display("FAIL rnd_word[%0d]: word=%h last=%b want %h %b",
                   cyc, bus.o_word, bus.o_last, 16'(q[0]), q.size() == 1);
        end
      end
      or_v = ($urandom_range(0, 3) != 0);
      bus.o_rdy = or_v;
      op = $urandom_range(0, 31);
      rd = $urandom_range(0, 31);
      rr = $urandom_range(0, 31);
      b = $urandom_range(0, 7);
      sel = $urandom_range(0, 3);
      case (sel)
        0: k = int'($urandom() % 4194304);
        1: k = $urandom_range(0, 300);
        2: k = ($urandom_range(0, 140) + 4194304 - 70) % 4194304;
        default: k = $urandom_range(0, 2100) + 4194304 - 2100;
      endcase
      if ($urandom_range(0, 1)) put(op, rd, rr, b, k);
      else idle();
      #1;
      rdy_exp = (q.size() == 0) || (q.size() == 1 && or_v);
      tests++;
      if (bus.i_rdy !== rdy_exp) begin
        fails++;
        $display("FAIL rnd_rdy[%0d]: i_rdy=%b want %b", cyc, bus.i_rdy, rdy_exp);
      end
      acc = bus.i_vld && rdy_exp;
      if (q.size() > 0 && or_v) begin
        void'(q.pop_front());
        exp_cnt++;
      end
      err_nx = 0;
      if (acc) begin
        enc(op, rd, rr, b, k, e, n, w1, w2);
        if (e) err_nx = 1;
        else begin
          q.push_back(w1);
          if (n == 2) q.push_back(w2);
        end
      end
      err_exp = err_nx;
      tick();
    end
    idle();
    bus.o_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      if (q.size() > 0) begin
        void'(q.pop_front());
        exp_cnt++;
      end
      tick();
    end
    tests++;
    if (bus.o_vld !== 0 || bus.o_cnt !== 16'(exp_cnt % 65536)) begin
      fails++;
      $display("FAIL rnd_cnt: vld=%b cnt=%0d want 0 %0d",
               bus.o_vld, bus.o_cnt, exp_cnt % 65536);
    end
  endtask

  initial begin
    idle();
    bus.o_rdy = 1;
    test_reset();
    test_ldi();
    test_back_to_back();
    test_jmp_stall();
    test_single_words();
    test_illegal();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
